// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory for the pipelined MIPS IF stage.
// A word-serial load port fills the array, then fetches return one registered word per cycle.
module imem_loadable #(
    parameter int                    ADDR_BITS  = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic                  addr_fault,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic [ADDR_BITS:0]    load_count,
    output logic                  load_done,
    output logic                  busy
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int PW    = ADDR_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           load_count_q, load_count_d;
    logic                    load_done_q, load_done_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic                    mem_we;
    logic                    fetch_fault;

    // Array is deliberately not reset so a mid-load reset keeps written words.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign fetch_fault = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_BITS + 2)) != 32'd0);
    assign load_ready  = (state_q == S_LOAD) && (wr_ptr_q < PW'(DEPTH));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        load_done_d  = 1'b0;
        instr_d      = NOP_WORD;
        valid_d      = 1'b0;
        fault_d      = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    load_count_d = '0;
                end
            end
            S_LOAD: begin
                if (load_valid && load_ready) begin
                    mem_we       = 1'b1;
                    wr_ptr_d     = wr_ptr_q + PW'(1);
                    load_count_d = load_count_q + PW'(1);
                    if (load_last || (wr_ptr_q == PW'(DEPTH - 1))) begin
                        state_d     = S_RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A new load wins over a same-cycle fetch and flushes the fetch outputs.
                if (load_start) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    load_count_d = '0;
                end else if (stall) begin
                    instr_d = instr_q;
                    valid_d = valid_q;
                    fault_d = fault_q;
                end else if (fetch_req) begin
                    instr_d = fetch_fault ? NOP_WORD : mem[fetch_addr[ADDR_BITS+1:2]];
                    valid_d = 1'b1;
                    fault_d = fetch_fault;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
            instr_q      <= NOP_WORD;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            load_done_q  <= load_done_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_BITS-1:0]] <= load_data;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign load_count  = load_count_q;
    assign load_done   = load_done_q;
    assign busy        = (state_q != S_RUN);
endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: table-driven fetch vectors through a scoreboard queue,
// plus hand-written load, overflow, load-over-fetch and mid-load reset sequences.
module tb_imem_loadable;
    localparam int AB = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          stall;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          addr_fault;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic [AB:0]   load_count;
    logic          load_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loadable #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .NOP_WORD(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .instruction(instruction), .instr_valid(instr_valid),
        .addr_fault(addr_fault), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_count(load_count), .load_done(load_done), .busy(busy)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        stl;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch cycle, queue its expected outputs, then pop and compare after the edge.
    task automatic fetch_cycle(input string name, input logic req, input logic [31:0] addr,
                               input logic stl, input logic [31:0] ei, input logic ev,
                               input logic ef);
        exp_t e;
        fetch_req  = req;
        fetch_addr = addr;
        stall      = stl;
        e.instr = ei; e.valid = ev; e.fault = ef;
        sbq.push_back(e);
        tick();
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", name, instruction);
        end else begin
            e = sbq.pop_front();
            chk({name, ".instr"}, instruction, e.instr);
            chk({name, ".valid"}, {31'd0, instr_valid}, {31'd0, e.valid});
            chk({name, ".fault"}, {31'd0, addr_fault}, {31'd0, e.fault});
        end
        fetch_req = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("start.busy", {31'd0, busy}, 32'd1);
        chk("start.ready", {31'd0, load_ready}, 32'd1);
        chk("start.count", {23'd0, load_count}, 32'd0);
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
    endtask

    logic [31:0] prog [4];
    vec_t        vecs [13];
    int          done_pulses;

    initial begin
        prog[0] = 32'h20040003; prog[1] = 32'h0c000003;
        prog[2] = 32'h1000ffff; prog[3] = 32'h23bdfff8;

        vecs[0]  = '{1'b1, 32'h4,        1'b0, 32'h0c000003, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h8,        1'b0, 32'h1000ffff, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'hC,        1'b1, 32'h1000ffff, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'hC,        1'b1, 32'h1000ffff, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'hC,        1'b1, 32'h1000ffff, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'hC,        1'b0, 32'h23bdfff8, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h6,        1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 32'h400,      1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h0,        1'b0, 32'h20040003, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h4,        1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 32'h1,        1'b0, 32'h00000000, 1'b1, 1'b1};

        reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        #12;
        chk("rst.instr", instruction, 32'h0);
        chk("rst.valid", {31'd0, instr_valid}, 32'd0);
        chk("rst.fault", {31'd0, addr_fault}, 32'd0);
        chk("rst.ready", {31'd0, load_ready}, 32'd0);
        chk("rst.count", {23'd0, load_count}, 32'd0);
        chk("rst.done", {31'd0, load_done}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Fetches in IDLE are ignored.
        fetch_cycle("idle_fetch0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        fetch_cycle("idle_fetch1", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0);
        chk("idle.busy", {31'd0, busy}, 32'd1);
        chk("idle.ready", {31'd0, load_ready}, 32'd0);

        // Four-word program load.
        start_load();
        for (int i = 0; i < 4; i++) begin
            push_word(prog[i], i == 3);
            chk("load.count", {23'd0, load_count}, i + 1);
            chk("load.done", {31'd0, load_done}, (i == 3) ? 32'd1 : 32'd0);
            chk("load.busy", {31'd0, busy}, (i == 3) ? 32'd0 : 32'd1);
            chk("load.ready", {31'd0, load_ready}, (i == 3) ? 32'd0 : 32'd1);
        end
        load_valid = 1'b0; load_last = 1'b0;

        for (int i = 0; i < 13; i++) begin
            fetch_cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].stl,
                        vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_fault);
            if (i == 0) chk("done_one_cycle", {31'd0, load_done}, 32'd0);
        end
        chk("run.count_held", {23'd0, load_count}, 32'd4);

        // load_start in RUN beats a same-cycle fetch and flushes the outputs.
        fetch_cycle("pre_flush", 1'b1, 32'h8, 1'b0, 32'h1000ffff, 1'b1, 1'b0);
        load_start = 1'b1;
        fetch_cycle("flush", 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        load_start = 1'b0;
        chk("flush.busy", {31'd0, busy}, 32'd1);
        chk("flush.count", {23'd0, load_count}, 32'd0);
        fetch_cycle("load_fetch_ignored", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0);

        // Overflow load: 257 words offered with no load_last.
        done_pulses = 0;
        for (int i = 0; i < 257; i++) begin
            push_word(32'hA0000000 + i, 1'b0);
            if (load_done) done_pulses++;
            if (i == 255) begin
                chk("ovf.ready_drop", {31'd0, load_ready}, 32'd0);
                chk("ovf.busy", {31'd0, busy}, 32'd0);
            end
        end
        load_valid = 1'b0;
        tick();
        if (load_done) done_pulses++;
        chk("ovf.done_pulses", done_pulses, 32'd1);
        chk("ovf.count", {23'd0, load_count}, 32'd256);
        fetch_cycle("ovf.mem0", 1'b1, 32'h0, 1'b0, 32'hA0000000, 1'b1, 1'b0);
        fetch_cycle("ovf.mem255", 1'b1, 32'h3FC, 1'b0, 32'hA00000FF, 1'b1, 1'b0);

        // Reset in the middle of a load keeps already-written words.
        start_load();
        push_word(32'hB0000000, 1'b0);
        push_word(32'hB0000001, 1'b0);
        load_valid = 1'b0;
        chk("mid.count_before", {23'd0, load_count}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.count", {23'd0, load_count}, 32'd0);
        chk("mid.busy", {31'd0, busy}, 32'd1);
        chk("mid.ready", {31'd0, load_ready}, 32'd0);
        chk("mid.done", {31'd0, load_done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("mid.idle_done", {31'd0, load_done}, 32'd0);
        start_load();
        push_word(32'hC0FFEE00, 1'b1);
        load_valid = 1'b0; load_last = 1'b0;
        chk("reload.done", {31'd0, load_done}, 32'd1);
        chk("reload.count", {23'd0, load_count}, 32'd1);
        chk("reload.busy", {31'd0, busy}, 32'd0);
        fetch_cycle("reload.mem0", 1'b1, 32'h0, 1'b0, 32'hC0FFEE00, 1'b1, 1'b0);
        fetch_cycle("reload.mem1_kept", 1'b1, 32'h4, 1'b0, 32'hB0000001, 1'b1, 1'b0);
        fetch_cycle("reload.idle_req", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous, run-time-loadable instruction memory for the pipelined MIPS CPU. It replaces the fixed combinational program ROM in the IF stage. A word-serial load port writes the program after reset. The fetch port then returns one instruction per cycle with a registered one-cycle read, honours pipeline stalls and flags bad fetch addresses.

## Interface
Parameters:
- ADDR_BITS, 8, word-index width; depth DEPTH = 2^ADDR_BITS words
- DATA_WIDTH, 32, instruction word width
- NOP_WORD, 32'h00000000, word driven when no valid instruction is present

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request for the current cycle
- fetch_addr  in  32  byte address of the fetch
- stall  in  1  IF-stage stall; hold fetch outputs
- instruction  out  DATA_WIDTH  fetched word, registered
- instr_valid  out  1  instruction holds a real fetch result
- addr_fault  out  1  last fetch was misaligned or out of range
- load_start  in  1  begin a program load
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_WIDTH  program word
- load_last  in  1  qualifies the final word of a load
- load_ready  out  1  memory accepts load words this cycle
- load_count  out  ADDR_BITS+1  number of words written by the current or most recent load
- load_done  out  1  one-cycle pulse when a load completes
- busy  out  1  state is not RUN

## Operation
- States are IDLE, LOAD and RUN. Reset enters IDLE. busy = (state != RUN).
- The memory array is not reset. Words not written by a load keep their previous contents.
- IDLE:
  - load_start moves to LOAD, clears the write pointer and clears load_count.
  - Fetch requests are ignored.
- LOAD:
  - load_ready = 1 while the write pointer is below DEPTH.
  - Each cycle with load_valid && load_ready writes load_data at the pointer, then increments the pointer and load_count.
  - A load ends on the accepted word that has load_last = 1, or on the accepted word at index DEPTH-1, whichever comes first. The state then moves to RUN.
  - load_start in LOAD is ignored. Words offered after termination are not accepted.
- RUN, fetch on each edge:
  - If stall = 1: instruction, instr_valid and addr_fault hold their values.
  - Else if fetch_req = 1:
    - A fault exists when fetch_addr[1:0] != 0 or fetch_addr[31:ADDR_BITS+2] != 0.
    - Without a fault, instruction <= mem[fetch_addr[ADDR_BITS+1:2]].
    - With a fault, instruction <= NOP_WORD.
    - In both cases instr_valid <= 1 and addr_fault <= fault.
  - Else: instruction <= NOP_WORD, instr_valid <= 0, addr_fault <= 0.
  - load_start in RUN takes priority over a same-cycle fetch. It moves to LOAD and flushes the fetch outputs. No fetch occurs that cycle.
- In IDLE and LOAD, fetch outputs are forced to instruction = NOP_WORD, instr_valid = 0, addr_fault = 0. stall is ignored in these states.
- A read during a write cannot occur, because fetch is disabled in LOAD.

## Timing
- Reset values:
  - state = IDLE, instruction = NOP_WORD.
  - instr_valid, addr_fault, load_ready, load_count and load_done = 0.
  - busy = 1.
- Fetch latency is one cycle: fetch_addr sampled at edge N produces instruction after edge N.
- LOAD start: load_start sampled at edge N puts state = LOAD and load_ready = 1 after edge N.
- Load throughput is one word per cycle while load_valid stays high.
- Load termination: if the terminating word is accepted at edge N, then after edge N:
  - state = RUN, load_done = 1 for exactly one cycle, load_ready = 0.
  - The first fetch is sampled at edge N+1.
- load_count holds its final value until the next load_start.
- Reset asserted mid-load:
  - Immediate return to IDLE and load_count = 0, with no load_done pulse.
  - Words already written remain in memory.

## Test plan
- Reset, then fetch_req = 1 at 0x0 while in IDLE -> instruction = 0, instr_valid = 0, busy = 1, load_ready = 0.
- Load 4 words 20040003, 0c000003, 1000ffff, 23bdfff8, with load_last on the 4th -> load_done pulses for one cycle, load_count = 4, busy = 0. Fetch 0x4 -> 0c000003 with instr_valid = 1 one cycle later.
- In RUN, fetch 0x8, then assert stall for 3 cycles while fetch_addr = 0xC -> instruction stays 1000ffff. Release stall -> 23bdfff8 next cycle.
- Fetch 0x6 -> addr_fault = 1, instruction = 0, instr_valid = 1. With ADDR_BITS = 8, fetch 0x400 -> addr_fault = 1. Fetch 0x0 -> addr_fault = 0.
- Stream 257 words with load_last never asserted -> load_ready drops after the 256th word, load_count = 256, load_done pulses once, and the 257th word is not written (mem[0] unchanged).
- Start a load, write 2 words, assert reset_n = 0 -> IDLE, load_count = 0, no load_done. Reload 1 word with load_last -> RUN, fetch 0x0 returns the new word.
